// File: rtl/bitstream_arb_packer.sv
// Fixed-priority arbiter over NUM_SRC bitstream producers feeding an MSB-first packer
// that emits big-endian OUT_BYTES words with backpressure and flush-to-byte support.
module bitstream_arb_packer #(
    parameter int NUM_SRC   = 7,
    parameter int MAX_BITS  = 64,
    parameter int OUT_BYTES = 8,
    parameter int SIZE_W    = 7,
    parameter int CNT_W     = 32
) (
    input  logic                                 CLOCK,
    input  logic                                 RESET,
    input  logic [NUM_SRC-1:0]                   src_valid,
    output logic [NUM_SRC-1:0]                   src_ready,
    input  logic [NUM_SRC*MAX_BITS-1:0]          src_val,
    input  logic [NUM_SRC*SIZE_W-1:0]            src_size,
    input  logic [NUM_SRC-1:0]                   src_flush,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [8*OUT_BYTES-1:0]               out_data,
    output logic [$clog2(OUT_BYTES+1)-1:0]       out_byte_cnt,
    output logic [CNT_W-1:0]                     total_byte_size,
    output logic                                 size_err
);
    localparam int W      = 8 * OUT_BYTES;
    localparam int ACC_W  = W + MAX_BITS;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int BC_W   = $clog2(OUT_BYTES + 1);
    localparam int GI_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_base;
    logic [FILL_W-1:0]   fill_q, fill_d, fill_base, shamt;
    logic                out_valid_q;
    logic [W-1:0]        out_data_q;
    logic [BC_W-1:0]     out_cnt_q, part_cnt;
    logic [CNT_W-1:0]    total_q;
    logic                size_err_q;

    logic                any_v, xfer, over, slot_free, load_full, load_part;
    logic [GI_W-1:0]     g;
    logic [SIZE_W-1:0]   raw_size, sz;
    logic [MAX_BITS-1:0] mask, field;

    always_comb begin
        any_v = 1'b0;
        g     = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (src_valid[i-1]) begin
                any_v = 1'b1;
                g     = GI_W'(i - 1);
            end
        end

        src_ready = '0;
        if (any_v && state_q == RUN && fill_q < FILL_W'(W))
            src_ready[g] = 1'b1;
        xfer = |(src_valid & src_ready);

        raw_size = src_size[g*SIZE_W +: SIZE_W];
        over     = raw_size > SIZE_W'(MAX_BITS);
        sz       = over ? SIZE_W'(MAX_BITS) : raw_size;
        for (int unsigned b = 0; b < MAX_BITS; b++)
            mask[b] = (b < 32'(sz));
        field = src_val[g*MAX_BITS +: MAX_BITS] & mask;

        slot_free = !out_valid_q || out_ready;
        load_full = slot_free && fill_q >= FILL_W'(W);
        load_part = slot_free && !load_full && state_q == FLUSH && fill_q != '0;
        part_cnt  = BC_W'(({1'b0, fill_q} + 9'd7) >> 3);

        // Bits below the fill are always zero, so a partial word is simply the top W bits.
        acc_base  = acc_q;
        fill_base = fill_q;
        if (load_full) begin
            acc_base  = acc_q << W;
            fill_base = fill_q - FILL_W'(W);
        end else if (load_part) begin
            acc_base  = '0;
            fill_base = '0;
        end

        shamt  = FILL_W'(ACC_W) - fill_base - FILL_W'(sz);
        acc_d  = acc_base;
        fill_d = fill_base;
        if (xfer) begin
            acc_d  = acc_base | ({{W{1'b0}}, field} << shamt);
            fill_d = fill_base + FILL_W'(sz);
        end

        state_d = state_q;
        if (state_q == RUN && xfer && src_flush[g])
            state_d = FLUSH;
        else if (state_q == FLUSH && fill_d == '0)
            state_d = RUN;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= RUN;
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            total_q     <= '0;
            size_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            if (slot_free) begin
                out_valid_q <= load_full || load_part;
                if (load_full || load_part) begin
                    out_data_q <= acc_q[ACC_W-1 -: W];
                    out_cnt_q  <= load_full ? BC_W'(OUT_BYTES) : part_cnt;
                end
            end
            if (out_valid_q && out_ready)
                total_q <= total_q + CNT_W'(out_cnt_q);
            if (xfer && over)
                size_err_q <= 1'b1;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_byte_cnt    = out_cnt_q;
    assign total_byte_size = total_q;
    assign size_err        = size_err_q;
endmodule
